regfile_seq: RTL and testbench

Register-operation sequencer that issues read and write requests to the team's 32×32 register file (`regfile`), which has a registered read and a synchronous write. It accepts one register-to-register command per valid/ready handshake. For each command it drives the two read addresses, waits one cycle for the registered read data, computes an ALU result and writes it back to the destination register. It sits between the command source (testbench or a later decode stage) and `regfile`, and owns all `regfile` port timing.

---
 rtl/regseq_pkg.sv | 25 ++
 rtl/regfile.sv | 36 +++
 rtl/regseq_alu.sv | 33 +++
 rtl/regfile_seq.sv | 119 +++++++++++
 tb/tb_regfile_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regseq_pkg.sv
// Shared definitions for the register-operation sequencer: default widths,
// opcode values and the sequencer state encoding.
package regseq_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile.sv
// 32-entry register file with registered read ports and a synchronous write.
// r0 is an ordinary register here; callers must avoid writing it.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        regs[i] <= '0;
      end
      readData1 <= '0;
      readData2 <= '0;
    end else begin
      readData1 <= regs[readReg1];
      readData2 <= regs[readReg2];
      if (write) begin
        regs[writeReg] <= writeData;
      end
    end
  end

endmodule

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer; opcodes 9-15 flag illegal and yield 0.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      // Shift amount is only the low five bits of the second operand
      OP_SLL: result_o = a_i << b_i[4:0];
      OP_SRL: result_o = a_i >> b_i[4:0];
      OP_LI:  result_o = imm_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_seq.sv
// Sequencer that runs one register-to-register command through the register
// file per handshake: READ presents addresses, EXEC latches the ALU, WRITE commits.
module regfile_seq
  import regseq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_readReg1,
  output logic [ADDR_W-1:0] rf_readReg2,
  input  logic [DATA_W-1:0] rf_readData1,
  input  logic [DATA_W-1:0] rf_readData2,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] aluResult;
  logic              aluIllegal;

  regseq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (op_q),
    .a_i       (rf_readData1),
    .b_i       (rf_readData2),
    .imm_i     (imm_q),
    .result_o  (aluResult),
    .illegal_o (aluIllegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rs_d    = in_rs;
          rt_d    = in_rt;
          rd_d    = in_rd;
          imm_d   = in_imm;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC: begin
        result_d = aluResult;
        err_d    = aluIllegal;
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // All outputs come from registers or the state register, never from in_*
  assign in_ready     = (state_q == ST_IDLE) && !rst;
  assign busy         = (state_q != ST_IDLE);
  assign rf_readReg1  = rs_q;
  assign rf_readReg2  = rt_q;
  assign rf_write     = (state_q == ST_WRITE) && !err_q && (rd_q != '0);
  assign rf_writeReg  = rd_q;
  assign rf_writeData = result_q;
  assign out_valid    = (state_q == ST_WRITE);
  assign out_rd       = rd_q;
  assign out_result   = result_q;
  assign out_err      = (state_q == ST_WRITE) && err_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq wired to the real regfile, checked against an
// architectural model of the 32 registers.
module tb_regfile_seq;
  import regseq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rfReset;
  logic          inValid;
  logic          inReady;
  logic [3:0]    inOp;
  logic [AW-1:0] inRs, inRt, inRd;
  logic [DW-1:0] inImm;
  logic [AW-1:0] rfReadReg1, rfReadReg2;
  logic [DW-1:0] rfReadData1, rfReadData2;
  logic          rfWrite;
  logic [AW-1:0] rfWriteReg;
  logic [DW-1:0] rfWriteData;
  logic          outValid;
  logic [AW-1:0] outRd;
  logic [DW-1:0] outResult;
  logic          outErr;
  logic          busy;

  always #5 clk = ~clk;

  regfile_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_op        (inOp),
    .in_rs        (inRs),
    .in_rt        (inRt),
    .in_rd        (inRd),
    .in_imm       (inImm),
    .rf_readReg1  (rfReadReg1),
    .rf_readReg2  (rfReadReg2),
    .rf_readData1 (rfReadData1),
    .rf_readData2 (rfReadData2),
    .rf_write     (rfWrite),
    .rf_writeReg  (rfWriteReg),
    .rf_writeData (rfWriteData),
    .out_valid    (outValid),
    .out_rd       (outRd),
    .out_result   (outResult),
    .out_err      (outErr),
    .busy         (busy)
  );

  regfile #(.DATA_W(DW), .ADDR_W(AW)) rf (
    .clock     (clk),
    .reset     (rfReset),
    .readReg1  (rfReadReg1),
    .readReg2  (rfReadReg2),
    .readData1 (rfReadData1),
    .readData2 (rfReadData2),
    .write     (rfWrite),
    .writeReg  (rfWriteReg),
    .writeData (rfWriteData)
  );

  int            total = 0;
  int            bad = 0;
  logic [31:0]   model [32];
  logic [31:0]   lastResult;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Architectural meaning of each opcode, written as plain arithmetic
  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm,
                                            output bit err);
    logic [31:0] scale;
    err   = 1'b0;
    scale = 32'd1 << b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: return a * scale;
      4'd7: return a / scale;
      4'd8: return imm;
      default: begin
        err = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  task automatic waitIdle(input string tag);
    int waitCnt = 0;
    while (inReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (inReady !== 1'b1) checkOutput({tag, "_readyTimeout"}, 32'(inReady), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] imm, input string tag);
    int          lat;
    bit          expErr;
    bit          expWrite;
    logic [31:0] expRes;
    waitIdle(tag);
    expRes   = refResult(op, model[rs], model[rt], imm, expErr);
    expWrite = !expErr && (rd != 5'd0);
    inOp  = op;
    inRs  = rs;
    inRt  = rt;
    inRd  = rd;
    inImm = imm;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput({tag, "_readAddr"}, 32'({rfReadReg1, rfReadReg2}), 32'({rs, rt}));
    end while (outValid !== 1'b1 && lat < 10);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    if (outValid === 1'b1) begin
      checkOutput({tag, "_rd"}, 32'(outRd), 32'(rd));
      checkOutput({tag, "_result"}, outResult, expRes);
      checkOutput({tag, "_err"}, 32'(outErr), 32'(expErr));
      checkOutput({tag, "_write"}, 32'(rfWrite), 32'(expWrite));
      if (expWrite) begin
        checkOutput({tag, "_wdata"}, 32'({rfWriteReg, rfWriteData[26:0]}), 32'({rd, expRes[26:0]}));
        model[rd] = expRes;
      end
    end
    lastResult = outResult;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int firstAcc;
    int secondAcc;
    int errPulses;
    logic [3:0] rop;

    rst = 1'b1;
    rfReset = 1'b1;
    inValid = 1'b0;
    inOp = '0; inRs = '0; inRt = '0; inRd = '0; inImm = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(inReady), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOutValid", 32'({outValid, outErr, rfWrite}), 32'd0);
    checkOutput("rstResult", outResult, 32'd0);
    rst = 1'b0;
    rfReset = 1'b0;
    #1;
    checkOutput("rstReleaseReady", 32'(inReady), 32'd1);
    @(negedge clk);

    applyStimulus(OP_LI, 5'd0, 5'd0, 5'd1, 32'd5, "liR1");
    applyStimulus(OP_LI, 5'd0, 5'd0, 5'd2, 32'd3, "liR2");
    applyStimulus(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, "addR3");
    checkOutput("addR3Value", lastResult, 32'd8);
    applyStimulus(OP_ADD, 5'd3, 5'd0, 5'd13, 32'd0, "readR3");
    checkOutput("readR3Value", lastResult, 32'd8);
    applyStimulus(OP_SUB, 5'd2, 5'd1, 5'd4, 32'd0, "subR4");
    checkOutput("subR4Value", lastResult, 32'hFFFF_FFFE);
    applyStimulus(OP_SLT, 5'd4, 5'd1, 5'd5, 32'd0, "sltR5");
    checkOutput("sltR5Value", lastResult, 32'd1);
    applyStimulus(OP_SRL, 5'd4, 5'd2, 5'd6, 32'd0, "srlR6");
    checkOutput("srlR6Value", lastResult, 32'h1FFF_FFFF);
    applyStimulus(OP_LI, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, "liR0");
    checkOutput("liR0Result", lastResult, 32'hDEAD_BEEF);
    applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd7, 32'd0, "addR7");
    checkOutput("addR7Value", lastResult, 32'd0);

    // Illegal opcode with in_valid held: only two accepts, four cycles apart
    applyStimulus(OP_LI, 5'd0, 5'd0, 5'd9, 32'h0000_1234, "liR9");
    waitIdle("holdValid");
    inOp = 4'd12; inRs = 5'd1; inRt = 5'd2; inRd = 5'd9; inImm = 32'd0;
    inValid = 1'b1;
    accepts = 0; firstAcc = -1; secondAcc = -1; errPulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) inValid = 1'b0;
      if (inValid && inReady) begin
        accepts++;
        if (firstAcc < 0) firstAcc = i;
        else secondAcc = i;
      end
      if (outValid) begin
        errPulses++;
        checkOutput("illErr", 32'(outErr), 32'd1);
        checkOutput("illWrite", 32'(rfWrite), 32'd0);
        checkOutput("illResult", outResult, 32'd0);
      end
      @(negedge clk);
    end
    checkOutput("holdAccepts", 32'(accepts), 32'd2);
    checkOutput("holdGap", 32'(secondAcc - firstAcc), 32'd4);
    checkOutput("holdErrPulses", 32'(errPulses), 32'd2);
    applyStimulus(OP_ADD, 5'd9, 5'd0, 5'd14, 32'd0, "readR9");
    checkOutput("readR9Value", lastResult, 32'h0000_1234);

    // Reset during EXEC of ADD r8 discards the command
    waitIdle("rstMid");
    inOp = OP_ADD; inRs = 5'd1; inRt = 5'd2; inRd = 5'd8; inImm = 32'd0;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstMidBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidWrite", 32'(rfWrite), 32'd0);
    checkOutput("rstMidIdle", 32'({busy, inReady}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstHoldQuiet", 32'({rfWrite, outValid}), 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("rstMidReady", 32'(inReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstAfterQuiet", 32'({rfWrite, outValid}), 32'd0);
    end
    applyStimulus(OP_ADD, 5'd8, 5'd0, 5'd15, 32'd0, "readR8");
    checkOutput("readR8Value", lastResult, 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(9, 15));
      else rop = 4'($urandom_range(0, 8));
      applyStimulus(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), $urandom, "rand");
    end

    // Dependent chain, each command reads the register written just before
    applyStimulus(OP_LI, 5'd0, 5'd0, 5'd1, 32'd1, "chainInit");
    for (int i = 1; i < 31; i++) begin
      applyStimulus(OP_ADD, 5'(i), 5'd1, 5'(i + 1), 32'd0, "chain");
      checkOutput("chainStep", lastResult, 32'(i + 1));
    end
    checkOutput("chainR31", lastResult, 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
